writeback_stage: RTL and testbench
==================================

// Module: writeback_stage
// PURPOSE
//  Final stage of the sequential RV64 core; drives the register file write port (rd_addr/rd_data/reg_write).
//  Accepts one retiring instruction per handshake, either an ALU result or a load.
//  For loads it waits for the data-memory response, then extracts and sign/zero-extends the addressed bytes.
//  Produces a single-cycle register write, or an error pulse for misaligned, illegal or timed-out loads.
// PARAMETERS
//  XLEN        64   datapath width; only 64 is supported
//  TIMEOUT     255  max cycles spent in WAIT_MEM before a timeout error; must be 1..255
// PORTS
//  clk           in   1     clock
//  rst           in   1     synchronous, active-high reset
//  in_valid      in   1     upstream presents a retiring instruction
//  in_ready      out  1     stage can accept; high only in IDLE
//  in_rd         in   5     destination register
//  in_reg_write  in   1     instruction writes rd
//  in_is_load    in   1     result comes from memory, not in_alu_result
//  in_funct3     in   3     load type: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU
//  in_addr_lo    in   3     byte offset of the load address within the doubleword
//  in_alu_result in   XLEN  result for non-loads
//  mem_rvalid    in   1     load data valid (one-cycle pulse)
//  mem_rdata     in   XLEN  aligned doubleword containing the load data
//  rd_addr       out  5     to register file
//  rd_data       out  XLEN  to register file
//  reg_write     out  1     to register file; one-cycle pulse
//  wb_done       out  1     instruction retired (pulse), including no-write and error cases
//  wb_error      out  1     misaligned, illegal funct3 or timeout (pulse, coincident with wb_done)
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=1; rd_addr=0, rd_data=0, reg_write=0, wb_done=0, wb_error=0; timeout counter=0.
//  Reset mid-operation abandons the instruction; no write occurs and a late mem_rvalid is ignored in IDLE.
//  Accept: in_valid & in_ready on a clock edge latches all in_* fields.
//  FSM states: IDLE, WAIT_MEM, WRITE, ERR.
//   IDLE -> WRITE     accepted non-load.
//   IDLE -> WAIT_MEM  accepted load, aligned, legal funct3.
//   IDLE -> ERR       accepted load that is misaligned or has funct3=111.
//   WAIT_MEM -> WRITE on mem_rvalid; extended data is latched on that edge.
//   WAIT_MEM -> ERR   when the counter reaches TIMEOUT without mem_rvalid. The counter clears on entry.
//     If mem_rvalid arrives in the same cycle the timeout expires, mem_rvalid wins.
//   WRITE -> IDLE and ERR -> IDLE unconditionally, after one cycle each.
//  Outputs are all registered. Non-load latency: accept edge +1 -> reg_write high for exactly one cycle.
//  Load latency: reg_write high in the cycle after the mem_rvalid edge.
//  Write suppression: in WRITE, reg_write=in_reg_write & (rd!=0); wb_done=1 regardless of suppression.
//  In ERR: reg_write=0, wb_done=1, wb_error=1.
//  rd_addr/rd_data hold their last values outside WRITE.
//  Alignment rules:
//   - H loads require addr_lo[0]=0; W loads require addr_lo[1:0]=0; D loads require addr_lo=0.
//   - Byte loads are always aligned.
//  Extraction: field = mem_rdata >> (8*addr_lo), truncated to 8/16/32/64 bits.
//   - funct3[2]=0 sign-extends to 64 bits; funct3[2]=1 zero-extends.
//  mem_rvalid outside WAIT_MEM is ignored. in_valid while in_ready=0 is held off with no side effect.
// STRUCTURE
//  Shared package (core_pkg): load funct3 constants (F3_LB..F3_LWU), the wb_state_t enum, XLEN.
//  Sub-module load_extend: combinational mem_rdata, addr_lo, funct3 -> 64-bit extended value plus
//  misaligned and illegal flags. It is reused by the forwarding logic later.
//  Top level holds the FSM, latched fields, timeout counter and output registers.
// TESTING
//  1. ALU op: rd=5, alu=0x1234 -> next cycle reg_write=1, rd_addr=5, rd_data=0x1234, wb_done=1; in_ready back to 1.
//  2. LB: addr_lo=3, mem_rdata=0x00000000_80000000 -> byte=0x80, rd_data=0xFFFFFFFF_FFFFFF80.
//     Same stimulus with LBU -> rd_data=0x80.
//  3. LW: addr_lo=4, mem_rdata=0x8765_4321_0000_0000 -> rd_data=0xFFFFFFFF_87654321.
//     Same stimulus with LWU -> 0x00000000_87654321.
//  4. LH with addr_lo=1 -> ERR next cycle: wb_error=1, wb_done=1, reg_write=0; no wait for memory.
//  5. Load with TIMEOUT=4 and no mem_rvalid -> wb_error pulse after 4 WAIT_MEM cycles.
//     Repeat with mem_rvalid on the 4th cycle -> normal write, no error.
//  6. rd=0 ALU op -> wb_done=1, reg_write=0.
//     Assert rst while in WAIT_MEM, then pulse mem_rvalid -> no write, in_ready=1.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the RV64 core: datapath width, load funct3 encodings
// and the writeback stage state type.
package core_pkg;

    localparam int XLEN = 64;

    // Load funct3 encodings; bit 2 selects zero-extension, bits 1:0 the size.
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        WRITE    = 2'd2,
        ERR      = 2'd3
    } wb_state_t;

endpackage

// File: rtl/load_extend.sv
// Combinational load formatter: picks the addressed field out of an aligned
// doubleword, sign- or zero-extends it, and flags misaligned or illegal loads.
// Kept standalone so the forwarding path can share it.
module load_extend
    import core_pkg::*;
(
    input  logic [63:0] mem_rdata_i,
    input  logic [2:0]  addr_lo_i,
    input  logic [2:0]  funct3_i,
    output logic [63:0] data_o,
    output logic        misaligned_o,
    output logic        illegal_o
);

    logic [63:0] shifted;

    assign shifted = mem_rdata_i >> {addr_lo_i, 3'b000};

    // Alignment depends only on the access size held in funct3[1:0].
    always_comb begin
        misaligned_o = 1'b0;
        case (funct3_i[1:0])
            2'b01:   misaligned_o = addr_lo_i[0];
            2'b10:   misaligned_o = |addr_lo_i[1:0];
            2'b11:   misaligned_o = |addr_lo_i;
            default: misaligned_o = 1'b0;
        endcase
    end

    // Truncate the shifted doubleword to the load size and extend it.
    always_comb begin
        data_o    = shifted;
        illegal_o = 1'b0;
        case (funct3_i)
            F3_LB:   data_o = {{56{shifted[7]}},  shifted[7:0]};
            F3_LH:   data_o = {{48{shifted[15]}}, shifted[15:0]};
            F3_LW:   data_o = {{32{shifted[31]}}, shifted[31:0]};
            F3_LD:   data_o = shifted;
            F3_LBU:  data_o = {56'd0, shifted[7:0]};
            F3_LHU:  data_o = {48'd0, shifted[15:0]};
            F3_LWU:  data_o = {32'd0, shifted[31:0]};
            default: begin
                data_o    = shifted;
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Final stage of the sequential RV64 core. Retires one instruction per
// handshake, waits for memory on loads, and drives the register file write
// port with single-cycle registered pulses.
module writeback_stage
    import core_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      in_rd,
    input  logic            in_reg_write,
    input  logic            in_is_load,
    input  logic [2:0]      in_funct3,
    input  logic [2:0]      in_addr_lo,
    input  logic [XLEN-1:0] in_alu_result,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [4:0]      rd_addr,
    output logic [XLEN-1:0] rd_data,
    output logic            reg_write,
    output logic            wb_done,
    output logic            wb_error
);

    wb_state_t       state_q;
    logic            in_ready_q;
    logic [4:0]      rd_q;
    logic            reg_write_en_q;
    logic [2:0]      funct3_q;
    logic [2:0]      addr_lo_q;
    logic [7:0]      cnt_q;
    logic [4:0]      rd_addr_q;
    logic [XLEN-1:0] rd_data_q;
    logic            reg_write_q;
    logic            wb_done_q;
    logic            wb_error_q;

    logic            accept;
    logic [2:0]      ext_funct3;
    logic [2:0]      ext_addr_lo;
    logic [63:0]     ext_data;
    logic            ext_misaligned;
    logic            ext_illegal;

    assign accept = in_valid && in_ready_q;

    // In IDLE the formatter checks the incoming load; afterwards it works on the latched fields.
    assign ext_funct3  = (state_q == IDLE) ? in_funct3  : funct3_q;
    assign ext_addr_lo = (state_q == IDLE) ? in_addr_lo : addr_lo_q;

    load_extend u_load_extend (
        .mem_rdata_i  (mem_rdata),
        .addr_lo_i    (ext_addr_lo),
        .funct3_i     (ext_funct3),
        .data_o       (ext_data),
        .misaligned_o (ext_misaligned),
        .illegal_o    (ext_illegal)
    );

    // Retirement FSM with registered outputs; pulses default low every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            in_ready_q     <= 1'b1;
            rd_q           <= 5'd0;
            reg_write_en_q <= 1'b0;
            funct3_q       <= 3'd0;
            addr_lo_q      <= 3'd0;
            cnt_q          <= 8'd0;
            rd_addr_q      <= 5'd0;
            rd_data_q      <= '0;
            reg_write_q    <= 1'b0;
            wb_done_q      <= 1'b0;
            wb_error_q     <= 1'b0;
        end else begin
            reg_write_q <= 1'b0;
            wb_done_q   <= 1'b0;
            wb_error_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        rd_q           <= in_rd;
                        reg_write_en_q <= in_reg_write;
                        funct3_q       <= in_funct3;
                        addr_lo_q      <= in_addr_lo;
                        cnt_q          <= 8'd0;
                        in_ready_q     <= 1'b0;
                        if (!in_is_load) begin
                            state_q     <= WRITE;
                            rd_addr_q   <= in_rd;
                            rd_data_q   <= in_alu_result;
                            reg_write_q <= in_reg_write && (in_rd != 5'd0);
                            wb_done_q   <= 1'b1;
                        end else if (ext_misaligned || ext_illegal) begin
                            state_q    <= ERR;
                            wb_done_q  <= 1'b1;
                            wb_error_q <= 1'b1;
                        end else begin
                            state_q <= WAIT_MEM;
                        end
                    end
                end
                WAIT_MEM: begin
                    if (mem_rvalid) begin
                        state_q     <= WRITE;
                        rd_addr_q   <= rd_q;
                        rd_data_q   <= ext_data;
                        reg_write_q <= reg_write_en_q && (rd_q != 5'd0);
                        wb_done_q   <= 1'b1;
                    end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                        state_q    <= ERR;
                        wb_done_q  <= 1'b1;
                        wb_error_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                WRITE, ERR: begin
                    state_q    <= IDLE;
                    in_ready_q <= 1'b1;
                end
                default: begin
                    state_q    <= IDLE;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign rd_addr   = rd_addr_q;
    assign rd_data   = rd_data_q;
    assign reg_write = reg_write_q;
    assign wb_done   = wb_done_q;
    assign wb_error  = wb_error_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed cases followed by random
// retirements, all compared against a behavioural model of the load rules.
module tb_writeback_stage;

    localparam int TO = 4;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic        in_reg_write;
    logic        in_is_load;
    logic [2:0]  in_funct3;
    logic [2:0]  in_addr_lo;
    logic [63:0] in_alu_result;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;
    logic [4:0]  rd_addr;
    logic [63:0] rd_data;
    logic        reg_write;
    logic        wb_done;
    logic        wb_error;

    int checks   = 0;
    int failures = 0;

    logic [4:0]  lastAddr = 5'd0;
    logic [63:0] lastData = 64'd0;

    writeback_stage #(.XLEN(64), .TIMEOUT(TO)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_rd         (in_rd),
        .in_reg_write  (in_reg_write),
        .in_is_load    (in_is_load),
        .in_funct3     (in_funct3),
        .in_addr_lo    (in_addr_lo),
        .in_alu_result (in_alu_result),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .reg_write     (reg_write),
        .wb_done       (wb_done),
        .wb_error      (wb_error)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%h, expected 0x%h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Behavioural load model: size from funct3, alignment by modulo, field by shift and mask.
    task automatic refLoad(input logic [63:0] rdata, input int addr, input int f3,
                           output bit err, output logic [63:0] val);
        int size;
        logic [63:0] mask;
        logic [63:0] field;
        case (f3 % 4)
            0:       size = 1;
            1:       size = 2;
            2:       size = 4;
            default: size = 8;
        endcase
        err   = (f3 == 7) || ((addr % size) != 0);
        mask  = (size == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * size)) - 64'd1);
        field = (rdata >> (8 * addr)) & mask;
        if (f3 < 4 && size < 8 && field[8 * size - 1])
            field = field | ~mask;
        val = field;
    endtask

    // Retire one instruction; rvAt is the WAIT_MEM cycle (1-based) carrying mem_rvalid, 0 for none.
    task automatic applyStimulus(input bit isLoad, input logic [4:0] rd, input bit regw,
                                 input logic [2:0] f3, input logic [2:0] addr,
                                 input logic [63:0] alu, input logic [63:0] rdata, input int rvAt);
        bit          expErr;
        logic [63:0] val;
        int          expLat;
        bit          expWrite;
        int          waited;
        if (isLoad) begin
            refLoad(rdata, int'(addr), int'(f3), expErr, val);
        end else begin
            expErr = 1'b0;
            val    = alu;
        end
        if (!isLoad || expErr) begin
            expLat = 1;
        end else if (rvAt >= 1 && rvAt <= TO) begin
            expLat = rvAt + 1;
        end else begin
            expLat = TO + 1;
            expErr = 1'b1;
        end
        expWrite = !expErr && regw && (rd != 5'd0);

        @(negedge clk);
        checkOutput("ready_idle", in_ready, 1);
        in_valid      = 1'b1;
        in_rd         = rd;
        in_reg_write  = regw;
        in_is_load    = isLoad;
        in_funct3     = f3;
        in_addr_lo    = addr;
        in_alu_result = alu;
        mem_rdata     = rdata;
        mem_rvalid    = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        mem_rvalid = 1'b0;
        waited     = 1;
        while (!wb_done && waited < 20) begin
            mem_rvalid    = (waited == rvAt);
            in_valid      = 1'($urandom_range(0, 1));
            in_rd         = 5'($urandom);
            in_is_load    = 1'($urandom_range(0, 1));
            in_alu_result = {$urandom, $urandom};
            @(posedge clk);
            #1;
            mem_rvalid = 1'b0;
            waited++;
        end
        in_valid = 1'b0;

        if (!expErr) begin
            lastAddr = rd;
            lastData = val;
        end
        checkOutput("latency", 64'(waited), 64'(expLat));
        checkOutput("wb_done", wb_done, 1);
        checkOutput("wb_error", wb_error, expErr);
        checkOutput("reg_write", reg_write, expWrite);
        checkOutput("rd_addr", rd_addr, lastAddr);
        checkOutput("rd_data", rd_data, lastData);

        @(posedge clk);
        #1;
        checkOutput("done_pulse", wb_done, 0);
        checkOutput("write_pulse", reg_write, 0);
        checkOutput("error_pulse", wb_error, 0);
        checkOutput("ready_back", in_ready, 1);
    endtask

    // Reset in the middle of a load, then a stray mem_rvalid that must be ignored.
    task automatic resetDuringWait();
        @(negedge clk);
        in_valid     = 1'b1;
        in_rd        = 5'd7;
        in_reg_write = 1'b1;
        in_is_load   = 1'b1;
        in_funct3    = 3'b011;
        in_addr_lo   = 3'd0;
        mem_rdata    = 64'hDEAD_BEEF_CAFE_F00D;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        lastAddr = 5'd0;
        lastData = 64'd0;
        checkOutput("rst_ready", in_ready, 1);
        checkOutput("rst_done", wb_done, 0);
        checkOutput("rst_rd_addr", rd_addr, 0);
        checkOutput("rst_rd_data", rd_data, 0);
        mem_rvalid = 1'b1;
        @(posedge clk);
        #1;
        mem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("late_rvalid_write", reg_write, 0);
            checkOutput("late_rvalid_done", wb_done, 0);
            @(posedge clk);
            #1;
        end
        checkOutput("late_rvalid_ready", in_ready, 1);
    endtask

    initial begin
        bit          isLoad;
        logic [2:0]  addr;
        int          rvAt;
        rst           = 1'b1;
        in_valid      = 1'b0;
        in_rd         = 5'd0;
        in_reg_write  = 1'b0;
        in_is_load    = 1'b0;
        in_funct3     = 3'd0;
        in_addr_lo    = 3'd0;
        in_alu_result = 64'd0;
        mem_rvalid    = 1'b0;
        mem_rdata     = 64'd0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_ready", in_ready, 1);
        checkOutput("reset_rd_addr", rd_addr, 0);
        checkOutput("reset_rd_data", rd_data, 0);
        checkOutput("reset_reg_write", reg_write, 0);
        checkOutput("reset_done", wb_done, 0);
        checkOutput("reset_error", wb_error, 0);
        rst = 1'b0;

        // ALU result straight to the register file.
        applyStimulus(1'b0, 5'd5, 1'b1, 3'd0, 3'd0, 64'h1234, 64'd0, 0);
        checkOutput("alu_value", rd_data, 64'h1234);

        // Byte loads, signed then unsigned.
        applyStimulus(1'b1, 5'd9, 1'b1, 3'b000, 3'd3, 64'd0, 64'h0000_0000_8000_0000, 2);
        checkOutput("lb_value", rd_data, 64'hFFFF_FFFF_FFFF_FF80);
        applyStimulus(1'b1, 5'd9, 1'b1, 3'b100, 3'd3, 64'd0, 64'h0000_0000_8000_0000, 1);
        checkOutput("lbu_value", rd_data, 64'h0000_0000_0000_0080);

        // Word loads from the upper half, signed then unsigned.
        applyStimulus(1'b1, 5'd10, 1'b1, 3'b010, 3'd4, 64'd0, 64'h8765_4321_0000_0000, 3);
        checkOutput("lw_value", rd_data, 64'hFFFF_FFFF_8765_4321);
        applyStimulus(1'b1, 5'd10, 1'b1, 3'b110, 3'd4, 64'd0, 64'h8765_4321_0000_0000, 1);
        checkOutput("lwu_value", rd_data, 64'h0000_0000_8765_4321);

        // Misaligned halfword and illegal funct3 fail without waiting for memory.
        applyStimulus(1'b1, 5'd11, 1'b1, 3'b001, 3'd1, 64'd0, 64'hFFFF, 0);
        applyStimulus(1'b1, 5'd11, 1'b1, 3'b111, 3'd0, 64'd0, 64'hFFFF, 0);

        // Timeout, then mem_rvalid on the very last WAIT_MEM cycle.
        applyStimulus(1'b1, 5'd12, 1'b1, 3'b011, 3'd0, 64'd0, 64'h0123_4567_89AB_CDEF, 0);
        applyStimulus(1'b1, 5'd12, 1'b1, 3'b011, 3'd0, 64'd0, 64'h0123_4567_89AB_CDEF, TO);
        checkOutput("ld_last_cycle", rd_data, 64'h0123_4567_89AB_CDEF);

        // Writes to x0 and writes with reg_write low still retire.
        applyStimulus(1'b0, 5'd0, 1'b1, 3'd0, 3'd0, 64'h5555, 64'd0, 0);
        applyStimulus(1'b0, 5'd3, 1'b0, 3'd0, 3'd0, 64'h6666, 64'd0, 0);

        resetDuringWait();

        // Random retirements with mixed types, offsets and memory latencies.
        for (int n = 0; n < 150; n++) begin
            isLoad = 1'($urandom_range(0, 1));
            addr   = ($urandom_range(0, 1) == 1) ? 3'd0 : 3'($urandom);
            rvAt   = $urandom_range(0, TO + 2);
            applyStimulus(isLoad, 5'($urandom), 1'($urandom_range(0, 3) != 0),
                          3'($urandom), addr, {$urandom, $urandom}, {$urandom, $urandom}, rvAt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop if the stimulus ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation did not complete");
    end

endmodule
